// File: rtl/ads1675_serial_rx.sv
// ---------------------------------------------------------------------------
// ads1675_serial_rx
//
// Purpose:
//    Captures the ADS1675 serial output (sclk / drdy / dout) by oversampling
//    it in the aclk domain, deserializes each MSB-first two's-complement
//    conversion, sign-extends it to OUT_WIDTH and presents it on a
//    valid/ready stream backed by a 2-entry buffer. Early frame starts are
//    reported as frame errors; samples that find the buffer full are dropped
//    and counted.
//
// Ports:
//    i_aclk          system clock (>= 3x sclk frequency)
//    i_aresetn       asynchronous active-low reset
//    i_enable        capture enable (level, sampled at frame start)
//    i_sclk          ADC serial clock (asynchronous)
//    i_drdy          ADC data ready, active-low frame start (asynchronous)
//    i_dout          ADC serial data, valid on sclk rising (asynchronous)
//    o_m_tdata       sign-extended sample
//    o_m_tvalid      sample available
//    i_m_tready      downstream accept
//    o_frame_err     one-cycle pulse, frame aborted by an early drdy
//    o_overflow      sticky, a sample was dropped on a full buffer
//    o_overflow_cnt  saturating count of dropped samples
//    i_clear_status  one-cycle pulse clearing o_overflow / o_overflow_cnt
// ---------------------------------------------------------------------------
module ads1675_serial_rx #(
   parameter int DATA_WIDTH  = 24,
   parameter int OUT_WIDTH   = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 i_aclk,
   input  logic                 i_aresetn,
   input  logic                 i_enable,
   input  logic                 i_sclk,
   input  logic                 i_drdy,
   input  logic                 i_dout,
   output logic [OUT_WIDTH-1:0] o_m_tdata,
   output logic                 o_m_tvalid,
   input  logic                 i_m_tready,
   output logic                 o_frame_err,
   output logic                 o_overflow,
   output logic [15:0]          o_overflow_cnt,
   input  logic                 i_clear_status
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PUSH  = 2'd2
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      if (val == 16'hFFFF) begin
         sat_inc16 = 16'hFFFF;
      end else begin
         sat_inc16 = val + 16'd1;
      end
   endfunction

   // Synchronizers and edge detection
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_drdy_sync;
   logic [SYNC_STAGES-1:0] r_dout_sync;
   logic                   r_sclk_d;
   logic                   r_drdy_d;
   logic                   r_sclk_rise;
   logic                   r_drdy_fall;
   logic                   r_dout_bit;
   logic                   w_sclk_s;
   logic                   w_drdy_s;
   logic                   w_dout_s;

   // FSM
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_bit_cnt;
   logic [CNT_W-1:0]       w_bit_cnt_nxt;
   logic [DATA_WIDTH-1:0]  r_shift;
   logic [DATA_WIDTH-1:0]  w_shift_nxt;
   logic                   r_frame_err;
   logic                   w_frame_err_nxt;
   logic                   w_push_req;

   // Output buffer and status
   logic [OUT_WIDTH-1:0]   r_head;
   logic [OUT_WIDTH-1:0]   r_tail;
   logic [1:0]             r_count;
   logic                   r_valid;
   logic [OUT_WIDTH-1:0]   w_push_data;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_push;
   logic                   w_drop;
   logic                   r_overflow;
   logic [15:0]            r_overflow_cnt;

   assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
   assign w_drdy_s = r_drdy_sync[SYNC_STAGES-1];
   assign w_dout_s = r_dout_sync[SYNC_STAGES-1];

   // Identical synchronizer chains keep sclk, drdy and dout mutually aligned.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_sclk_sync <= '0;
         r_drdy_sync <= '1;
         r_dout_sync <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
         r_drdy_sync <= {r_drdy_sync[SYNC_STAGES-2:0], i_drdy};
         r_dout_sync <= {r_dout_sync[SYNC_STAGES-2:0], i_dout};
      end
   end

   // Registered edge pulses; r_dout_bit is delayed with them so it is the bit
   // that was present when the sclk rising edge was seen.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_sclk_d    <= 1'b0;
         r_drdy_d    <= 1'b1;
         r_sclk_rise <= 1'b0;
         r_drdy_fall <= 1'b0;
         r_dout_bit  <= 1'b0;
      end else begin
         r_sclk_d    <= w_sclk_s;
         r_drdy_d    <= w_drdy_s;
         r_sclk_rise <= w_sclk_s & ~r_sclk_d;
         r_drdy_fall <= ~w_drdy_s & r_drdy_d;
         r_dout_bit  <= w_dout_s;
      end
   end

   // FSM state, bit counter, shift register and frame error pulse.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_frame_err <= w_frame_err_nxt;
      end
   end

   // FSM next state. enable only matters when a frame starts; an early drdy
   // restarts the frame (or drops to IDLE when capture is disabled).
   always_comb begin
      w_state_nxt     = r_state;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_shift_nxt     = r_shift;
      w_frame_err_nxt = 1'b0;
      w_push_req      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_drdy_fall && i_enable) begin
               w_state_nxt   = ST_SHIFT;
               w_bit_cnt_nxt = '0;
               w_shift_nxt   = '0;
            end else begin
               w_state_nxt   = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (r_drdy_fall) begin
               w_frame_err_nxt = 1'b1;
               w_bit_cnt_nxt   = '0;
               w_shift_nxt     = '0;
               if (i_enable) begin
                  w_state_nxt = ST_SHIFT;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (r_sclk_rise) begin
               w_shift_nxt   = {r_shift[DATA_WIDTH-2:0], r_dout_bit};
               w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                  w_state_nxt = ST_PUSH;
               end else begin
                  w_state_nxt = ST_SHIFT;
               end
            end else begin
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_PUSH: begin
            w_push_req  = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_push_data = {{(OUT_WIDTH-DATA_WIDTH){r_shift[DATA_WIDTH-1]}}, r_shift};
   // A pop in the same cycle frees a slot, so a full buffer only blocks a
   // push when the head is not being accepted.
   assign w_pop       = r_valid & i_m_tready;
   assign w_full      = (r_count == 2'd2) & ~w_pop;
   assign w_push      = w_push_req & ~w_full;
   assign w_drop      = w_push_req & w_full;

   // Two-entry buffer: r_head drives the output directly, r_tail backs it up.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
         r_valid <= 1'b0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_head <= w_push_data;
               end else begin
                  r_tail <= w_push_data;
               end
               r_count <= r_count + 2'd1;
               r_valid <= 1'b1;
            end
            2'b01: begin
               if (r_count == 2'd2) begin
                  r_head <= r_tail;
               end else begin
                  r_head <= r_head;
               end
               r_count <= r_count - 2'd1;
               r_valid <= (r_count == 2'd2);
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_head <= w_push_data;
               end else begin
                  r_head <= r_tail;
                  r_tail <= w_push_data;
               end
               r_valid <= 1'b1;
            end
            default: begin
               r_count <= r_count;
            end
         endcase
      end
   end

   // Overflow status; a drop coinciding with clear leaves exactly one count.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_overflow     <= 1'b0;
         r_overflow_cnt <= 16'd0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (i_clear_status) begin
            r_overflow_cnt <= 16'd1;
         end else begin
            r_overflow_cnt <= sat_inc16(r_overflow_cnt);
         end
      end else if (i_clear_status) begin
         r_overflow     <= 1'b0;
         r_overflow_cnt <= 16'd0;
      end else begin
         r_overflow     <= r_overflow;
         r_overflow_cnt <= r_overflow_cnt;
      end
   end

   assign o_m_tdata      = r_head;
   assign o_m_tvalid     = r_valid;
   assign o_frame_err    = r_frame_err;
   assign o_overflow     = r_overflow;
   assign o_overflow_cnt = r_overflow_cnt;

endmodule
